// File: rtl/reaction_meter.sv
// Reaction-time meter: arms on start, counts 1 ms ticks from the lamp to the
// first button press and reports the time as 4 BCD digits, with early-press
// and 9999 ms timeout outcomes.
// Optional feature: define BEST_TIME_EN to add the best_bcd output, which
// keeps the fastest valid time seen since reset.
module reaction_meter #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        led,
  input  logic        btn,
  output logic [15:0] ms_bcd,
  output logic        done,
  output logic        early,
  output logic        timeout,
  output logic        armed
`ifdef BEST_TIME_EN
  ,
  output logic [15:0] best_bcd
`endif
);

  localparam int unsigned DIV_W    = 16;
  localparam int unsigned MS_W     = 16;
  localparam int unsigned DIGITS   = 4;
  localparam logic [MS_W-1:0]  MS_MAX   = 16'h9999;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_COUNT,
    S_DONE,
    S_EARLY,
    S_TIMEOUT
  } state_e;

  state_e            state_q, state_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              btn_q, btn_d;
  logic              press;
  logic              div_wrap;
  logic [MS_W-1:0]   ms_inc;
  logic              carry;
`ifdef BEST_TIME_EN
  logic [MS_W-1:0]   best_q, best_d;
`endif

  // Button edge detector: a held button only ever yields one press pulse
  always_comb begin
    btn_d = btn;
    press = btn & ~btn_q;
  end

  // BCD increment of the current time, rippling carries digit by digit
  always_comb begin
    ms_inc = ms_q;
    carry  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (ms_q[4*i +: 4] == 4'd9) begin
          ms_inc[4*i +: 4] = 4'd0;
        end else begin
          ms_inc[4*i +: 4] = ms_q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // Millisecond tick marker from the clock divider
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
      div_q   <= '0;
      btn_q   <= 1'b0;
`ifdef BEST_TIME_EN
      best_q  <= MS_MAX;
`endif
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      div_q   <= div_d;
      btn_q   <= btn_d;
`ifdef BEST_TIME_EN
      best_q  <= best_d;
`endif
    end
  end

  // Next-state and datapath update; start restarts the trial from any state
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    div_d   = div_q;
    if (start) begin
      state_d = S_ARMED;
      ms_d    = '0;
      div_d   = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (led) begin
            if (press) begin
              state_d = S_DONE;
              ms_d    = '0;
            end else begin
              state_d = S_COUNT;
              div_d   = '0;
            end
          end else if (press) begin
            state_d = S_EARLY;
          end
        end
        S_COUNT: begin
          // A press wins over a coincident tick so the frozen time is not bumped
          if (press) begin
            state_d = S_DONE;
          end else if (div_wrap) begin
            div_d = '0;
            if (ms_q == MS_MAX) begin
              state_d = S_TIMEOUT;
            end else begin
              ms_d = ms_inc;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BEST_TIME_EN
  // Best time tracks the minimum over entries into DONE; packed BCD orders like binary
  always_comb begin
    best_d = best_q;
    if ((state_d == S_DONE) && (state_q != S_DONE) && (ms_d < best_q)) begin
      best_d = ms_d;
    end
  end
`endif

  // Output decode from the registered state and time
  always_comb begin
    ms_bcd  = ms_q;
    done    = (state_q == S_DONE);
    early   = (state_q == S_EARLY);
    timeout = (state_q == S_TIMEOUT);
    armed   = (state_q == S_ARMED) || (state_q == S_COUNT);
`ifdef BEST_TIME_EN
    best_bcd = best_q;
`endif
  end

endmodule

// File: tb/tb_reaction_meter.sv
// Self-checking bench for reaction_meter (TICK_DIV = 4). A behavioural model
// derives the displayed time arithmetically from the number of clock edges
// spent counting; a negedge process compares every cycle.
// Define BEST_TIME_EN to also exercise best_bcd.
module tb_reaction_meter;

  localparam int T = 4;

  localparam int M_IDLE    = 0;
  localparam int M_ARMED   = 1;
  localparam int M_COUNT   = 2;
  localparam int M_DONE    = 3;
  localparam int M_EARLY   = 4;
  localparam int M_TIMEOUT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        led = 1'b0;
  logic        btn = 1'b0;
  logic [15:0] ms_bcd;
  logic        done, early, timeout, armed;
`ifdef BEST_TIME_EN
  logic [15:0] best_bcd;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reaction_meter #(.TICK_DIV(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .led     (led),
    .btn     (btn),
    .ms_bcd  (ms_bcd),
    .done    (done),
    .early   (early),
    .timeout (timeout),
    .armed   (armed)
`ifdef BEST_TIME_EN
    ,
    .best_bcd(best_bcd)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_c = clock edges elapsed since the lamp was seen; the time shown is c/T ms.
  int m_st   = M_IDLE;
  int m_c    = 0;
  int m_ms   = 0;
  int m_best = 9999;
  bit m_btn_prev = 1'b0;
  wire m_press = btn & ~m_btn_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= M_IDLE; m_c <= 0; m_ms <= 0; m_btn_prev <= 1'b0; m_best <= 9999;
    end else begin
      m_btn_prev <= btn;
      if (start) begin
        m_st <= M_ARMED; m_ms <= 0; m_c <= 0;
      end else if (m_st == M_ARMED) begin
        if (m_press && !led) m_st <= M_EARLY;
        else if (led && m_press) begin
          m_st <= M_DONE; m_ms <= 0; m_best <= 0;
        end else if (led) begin
          m_st <= M_COUNT; m_c <= 0;
        end
      end else if (m_st == M_COUNT) begin
        m_c <= m_c + 1;
        if (m_press) begin
          m_st <= M_DONE; m_ms <= m_c / T;
          if (m_c / T < m_best) m_best <= m_c / T;
        end else if ((m_c + 1) % T == 0) begin
          if ((m_c + 1) / T > 9999) begin
            m_st <= M_TIMEOUT; m_ms <= 9999;
          end else m_ms <= (m_c + 1) / T;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_ms_bcd", 32'(ms_bcd), 32'(to_bcd(m_ms)));
    chk("cyc_flags", 32'({done, early, timeout, armed}),
        32'({m_st == M_DONE, m_st == M_EARLY, m_st == M_TIMEOUT,
             (m_st == M_ARMED) || (m_st == M_COUNT)}));
`ifdef BEST_TIME_EN
    chk("cyc_best", 32'(best_bcd), 32'(to_bcd(m_best)));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Full trial: press lands ms*T+1 edges after the lamp edge
  task automatic timed_trial(input int ms);
    btn = 1'b0; led = 1'b0;
    do_start();
    led = 1'b1; tick(); led = 1'b0;
    repeat (ms * T) tick();
    btn = 1'b1; tick(); btn = 1'b0; tick();
  endtask

  task automatic early_trial();
    btn = 1'b0; led = 1'b0;
    do_start();
    btn = 1'b1; tick(); btn = 1'b0; tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset_flags", 32'({done, early, timeout, armed}), 32'h0);
    chk("reset_ms", 32'(ms_bcd), 32'h0);
    reset = 1'b0;
    tick();

    // Measured trial of 37 ms
    timed_trial(37);
    chk("t37_ms", 32'(ms_bcd), 32'h0037);
    chk("t37_done", 32'({done, early}), 32'b10);

    // Early press, then lamp and presses are ignored, start re-arms
    do_start();
    btn = 1'b1; tick(); btn = 1'b0;
    chk("early_flag", 32'({early, ms_bcd}), 32'h1_0000);
    led = 1'b1; tick(); btn = 1'b1; tick(); btn = 1'b0; tick(); led = 1'b0;
    chk("early_hold", 32'({early, done, ms_bcd}), 32'h2_0000);
    do_start();
    chk("early_rearm", 32'({armed, early}), 32'b10);

    // Lamp and press in the same cycle
    led = 1'b1; btn = 1'b1; tick(); led = 1'b0; btn = 1'b0;
    chk("coinc_ms", 32'({done, ms_bcd}), 32'h1_0000);

    // Randomized trials
    for (int t = 0; t < 20; t++) begin
      btn = 1'b0; led = 1'b0;
      do_start();
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 4) == 0) begin
        btn = 1'b1; tick(); btn = 1'b0;
      end else begin
        led = 1'b1;
        if ($urandom_range(0, 3) == 0) btn = 1'b1;
        tick();
        btn = 1'b0;
        repeat ($urandom_range(0, 120)) begin
          led = 1'($urandom_range(0, 1));
          tick();
        end
        if ($urandom_range(0, 7) == 0) do_start();
        btn = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        btn = 1'b0;
      end
      repeat (3) begin
        led = 1'($urandom_range(0, 1));
        btn = 1'($urandom_range(0, 1));
        tick();
      end
    end

    // Timeout run with carry checkpoints
    btn = 1'b0; led = 1'b0;
    do_start();
    led = 1'b1; tick(); led = 1'b0;
    for (int c = 1; c <= 10000 * T + 4; c++) begin
      tick();
      if (c == 99 * T)   chk("carry_0099", 32'(ms_bcd), 32'h0099);
      if (c == 100 * T)  chk("carry_0100", 32'(ms_bcd), 32'h0100);
      if (c == 999 * T)  chk("carry_0999", 32'(ms_bcd), 32'h0999);
      if (c == 1000 * T) chk("carry_1000", 32'(ms_bcd), 32'h1000);
    end
    chk("timeout_ms", 32'({timeout, ms_bcd}), 32'h1_9999);
    btn = 1'b1; tick(); btn = 1'b0; tick();
    chk("timeout_hold", 32'({timeout, done, ms_bcd}), 32'h2_9999);

    // Asynchronous reset in mid-count, then a held button never presses
    do_start();
    led = 1'b1; tick(); led = 1'b0;
    repeat (250 * T) tick();
    chk("pre_reset_ms", 32'(ms_bcd), 32'h0250);
    btn = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 32'({armed, ms_bcd}), 32'h0_0000);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_wait", 32'({armed, done}), 32'b00);
    do_start();
    led = 1'b1; tick();
    repeat (20) tick();
    led = 1'b0;
    chk("held_btn", 32'({armed, done}), 32'b10);
    btn = 1'b0; tick();

`ifdef BEST_TIME_EN
    // Best time over a sequence of trials
    reset = 1'b1; tick(); reset = 1'b0; tick();
    chk("best_reset", 32'(best_bcd), 32'h9999);
    timed_trial(120);
    chk("best_0120", 32'(best_bcd), 32'h0120);
    timed_trial(85);
    chk("best_0085", 32'(best_bcd), 32'h0085);
    early_trial();
    chk("best_early", 32'(best_bcd), 32'h0085);
    timed_trial(300);
    chk("best_0300", 32'(best_bcd), 32'h0085);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_meter.md
REACTION_METER -- requirements
Module: reaction_meter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per 1 ms tick (50 MHz clk); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  synchronous pulse: arm a new trial; also clears a finished trial.
REQ-005 SHALL have port led  input  1  stimulus lamp from the delay generator; high = player must react.
REQ-006 SHALL have port btn  input  1  player button, already debounced and synchronous to clk, active-high level.
REQ-007 SHALL have port ms_bcd  output  16  reaction time in ms, 4 BCD digits, [15:12] = thousands.
REQ-008 SHALL have port done  output  1  high while in DONE state (valid time on ms_bcd).
REQ-009 SHALL have port early  output  1  high while in EARLY state (press before led).
REQ-010 SHALL have port timeout  output  1  high while in TIMEOUT state (no press by 9999 ms).
REQ-011 SHALL have port armed  output  1  high in ARMED or COUNT (trial in progress).

Function
REQ-012 SHALL register btn once and form press = btn & ~btn_q, a one-cycle rising-edge pulse; a held button SHALL never generate a second press.
REQ-013 SHALL implement states IDLE, ARMED, COUNT, DONE, EARLY, TIMEOUT; all outputs registered or decoded only from state.
REQ-014 IDLE: start -> ARMED; ms_bcd cleared to 0000 on the same edge.
REQ-015 ARMED: press with led=0 -> EARLY; led=1 and press in same cycle -> DONE with ms_bcd=0000; led=1 without press -> COUNT, tick divider cleared to 0.
REQ-016 COUNT: divider counts 0..TICK_DIV-1; on wrap ms_bcd increments by 1 in BCD (digit 9 -> 0 with carry into next digit).
REQ-017 COUNT: first increment SHALL occur exactly TICK_DIV cycles after entry; press -> DONE, freezing ms_bcd at current value; press coincident with a wrap SHALL NOT apply that increment.
REQ-018 COUNT: a wrap while ms_bcd=9999 with no press -> TIMEOUT, ms_bcd held at 9999 (no wrap-around to 0000).
REQ-019 COUNT: led falling back to 0 SHALL be ignored; counting continues until press or timeout.
REQ-020 DONE, EARLY, TIMEOUT: hold outputs and ms_bcd; ignore led and press; start -> ARMED with ms_bcd cleared.
REQ-021 start while ARMED or COUNT SHALL restart the trial: -> ARMED, ms_bcd=0000, divider=0.
REQ-022 ms_bcd SHALL never hold a non-BCD digit (A-F).

Reset
REQ-023 reset high SHALL immediately force state=IDLE, ms_bcd=0000, divider=0, btn_q=0, best register (if present) =9999, independent of clk.
REQ-024 Reset asserted mid-COUNT SHALL discard the trial; after release the block SHALL wait in IDLE for start.
REQ-025 After reset, done=early=timeout=armed=0.

Configuration
REQ-026 With macro BEST_TIME_EN defined, SHALL add output best_bcd (16 bits): on each entry to DONE, if ms_bcd < best_bcd then best_bcd <= ms_bcd; EARLY/TIMEOUT SHALL NOT update it; only reset restores 9999.
REQ-027 Without BEST_TIME_EN, best_bcd port and its register SHALL be absent; all other behaviour identical.

Verification (TICK_DIV=4)
REQ-028 reset, start, led=1 for 1 cycle, press after 4*37 cycles -> DONE, ms_bcd=0037, early=0.
REQ-029 start, press while led=0 -> EARLY next edge, ms_bcd=0000; further led/press ignored; start -> ARMED.
REQ-030 start, led=1 and press in same cycle -> DONE, ms_bcd=0000.
REQ-031 start, led=1, no press for 4*10000 cycles -> TIMEOUT, ms_bcd=9999; count 0099->0100 and 0999->1000 carries observed en route.
REQ-032 start, led=1, assert reset at ms_bcd=0250 -> IDLE, ms_bcd=0000 asynchronously; btn held high through start/led -> no press, no DONE.
REQ-033 BEST_TIME_EN: trials 0120, 0085, early, 0300 -> best_bcd 0120, 0085, 0085, 0085.
